// File: rtl/iuq_ram_seq.sv
// iuq_ram_seq: RAM instruction sequencer for the IU.
//
// Buffers pervasive-RAMmed instructions in one FIFO per thread, arbitrates
// round-robin among threads onto a single 36-bit injection bus toward the
// instruction buffer, and holds each head entry until completion. The head
// is replayed on a completion flush, or on a WAIT timeout when the optional
// feature is built in.
//
// Optional feature macro: IUQ_RAM_TIMEOUT_EN
//   defined   - per-thread WAIT counters; a counter reaching TIMEOUT_CYCLES
//               forces a replay and pulses iu_pc_ram_timeout[t]
//   undefined - no counters, iu_pc_ram_timeout tied to 0
//
// Ports:
//   nclk, rst               clock, synchronous active-high reset
//   pc_iu_ram_instr/_ext    instruction word and extension bits to enqueue
//   pc_iu_ram_issue         enqueue strobe
//   pc_iu_ram_active        target thread (lowest set bit wins)
//   iu_pc_ram_done/_tid     completion strobe and its thread
//   cp_flush                per-thread completion flush (replay head)
//   ib_rm_rdy               ib accepts an injection for thread t
//   rm_ib_iu3_val/_instr    injection bus (at most one val bit set)
//   iu_pc_ram_full          registered per-thread FIFO full
//   iu_pc_ram_overflow      pulse: enqueue dropped on a full FIFO
//   iu_pc_ram_timeout       pulse per timeout replay
//
// Per-thread states:
//   state    | meaning
//   ST_IDLE  | nothing outstanding; waits for the FIFO to become non-empty
//   ST_ISSUE | head entry wants (or holds) the injection bus
//   ST_WAIT  | head entry accepted by ib; waiting for done, flush or timeout

module iuq_ram_seq #(
    parameter int THREADS        = 2,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic               nclk,
    input  logic               rst,
    input  logic [31:0]        pc_iu_ram_instr,
    input  logic [3:0]         pc_iu_ram_instr_ext,
    input  logic               pc_iu_ram_issue,
    input  logic [THREADS-1:0] pc_iu_ram_active,
    input  logic               iu_pc_ram_done,
    input  logic [THREADS-1:0] iu_pc_ram_done_tid,
    input  logic [THREADS-1:0] cp_flush,
    input  logic [THREADS-1:0] ib_rm_rdy,
    output logic [THREADS-1:0] rm_ib_iu3_val,
    output logic [35:0]        rm_ib_iu3_instr,
    output logic [THREADS-1:0] iu_pc_ram_full,
    output logic               iu_pc_ram_overflow,
    output logic [THREADS-1:0] iu_pc_ram_timeout
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (THREADS > 1) ? $clog2(THREADS) : 1;

    if (THREADS < 1 || THREADS > 4) begin : g_bad_threads
        $error("iuq_ram_seq: THREADS must be 1..4");
    end
    if (DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("iuq_ram_seq: DEPTH must be a power of 2 in 2..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("iuq_ram_seq: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t             state_q   [THREADS];
    state_t             state_d   [THREADS];
    logic [35:0]        mem       [THREADS][DEPTH];
    logic [PW-1:0]      wr_ptr_q  [THREADS];
    logic [PW-1:0]      rd_ptr_q  [THREADS];
    logic [CW-1:0]      count_q   [THREADS];
    logic [CW-1:0]      count_d   [THREADS];

    logic [THREADS-1:0] enq_sel;
    logic [THREADS-1:0] push;
    logic [THREADS-1:0] pop;
    logic               drop;
    logic [THREADS-1:0] timeout_hit;
    logic [THREADS-1:0] replay;

    logic [THREADS-1:0] out_val_q;
    logic [35:0]        out_instr_q;
    logic [TW-1:0]      rr_ptr_q;
    logic [THREADS-1:0] full_q;
    logic               ovf_q;

    logic [THREADS-1:0] cand;
    logic               gnt_found;
    logic [TW-1:0]      gnt_idx;
    logic               xfer;
    logic               load_en;

    // Isolate the lowest set bit so a non-one-hot target picks one thread.
    assign enq_sel = pc_iu_ram_issue ? (pc_iu_ram_active & (~pc_iu_ram_active + THREADS'(1)))
                                     : '0;

    assign replay = cp_flush | timeout_hit;

    // A same-cycle pop frees the slot, so a write into a full FIFO survives.
    always_comb begin
        pop  = '0;
        push = '0;
        drop = 1'b0;
        for (int t = 0; t < THREADS; t++) begin
            count_d[t] = count_q[t];
            pop[t]     = iu_pc_ram_done && iu_pc_ram_done_tid[t] && (state_q[t] == ST_WAIT);
            push[t]    = enq_sel[t] && ((count_q[t] != CW'(DEPTH)) || pop[t]);
            if (enq_sel[t] && (count_q[t] == CW'(DEPTH)) && !pop[t]) begin
                drop = 1'b1;
            end
            if (push[t] && !pop[t]) begin
                count_d[t] = count_q[t] + CW'(1);
            end else if (pop[t] && !push[t]) begin
                count_d[t] = count_q[t] - CW'(1);
            end
        end
    end

    always_ff @(posedge nclk) begin
        if (rst) begin
            for (int t = 0; t < THREADS; t++) begin
                wr_ptr_q[t] <= '0;
                rd_ptr_q[t] <= '0;
                count_q[t]  <= '0;
            end
            full_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            for (int t = 0; t < THREADS; t++) begin
                if (push[t]) wr_ptr_q[t] <= wr_ptr_q[t] + PW'(1);
                if (pop[t])  rd_ptr_q[t] <= rd_ptr_q[t] + PW'(1);
                count_q[t] <= count_d[t];
                full_q[t]  <= (count_d[t] == CW'(DEPTH));
            end
            ovf_q <= drop;
        end
    end

    always_ff @(posedge nclk) begin
        for (int t = 0; t < THREADS; t++) begin
            if (push[t]) begin
                mem[t][wr_ptr_q[t]] <= {pc_iu_ram_instr, pc_iu_ram_instr_ext};
            end
        end
    end

    // Per-thread FSM.
    always_ff @(posedge nclk) begin
        for (int t = 0; t < THREADS; t++) begin
            if (rst) state_q[t] <= ST_IDLE;
            else     state_q[t] <= state_d[t];
        end
    end

    always_comb begin
        for (int t = 0; t < THREADS; t++) begin
            state_d[t] = state_q[t];
            case (state_q[t])
                ST_IDLE: begin
                    if (count_q[t] != '0) state_d[t] = ST_ISSUE;
                end
                ST_ISSUE: begin
                    // A flush coinciding with acceptance still replays.
                    if (out_val_q[t] && ib_rm_rdy[t] && !replay[t]) state_d[t] = ST_WAIT;
                end
                ST_WAIT: begin
                    if (pop[t])         state_d[t] = ST_IDLE;
                    else if (replay[t]) state_d[t] = ST_ISSUE;
                end
                default: state_d[t] = ST_IDLE;
            endcase
        end
    end

    // Round-robin grant among ISSUE threads not already on the bus.
    function automatic logic [TW-1:0] rr_idx(input logic [TW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= THREADS) s = s - THREADS;
        return TW'(s);
    endfunction

    always_comb begin
        cand      = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int t = 0; t < THREADS; t++) begin
            cand[t] = (state_q[t] == ST_ISSUE) && !out_val_q[t] && !replay[t];
        end
        for (int i = 0; i < THREADS; i++) begin
            if (!gnt_found && cand[rr_idx(rr_ptr_q, i)]) begin
                gnt_found = 1'b1;
                gnt_idx   = rr_idx(rr_ptr_q, i);
            end
        end
    end

    assign xfer    = |(out_val_q & ib_rm_rdy);
    assign load_en = ~(|out_val_q) | xfer;

    always_ff @(posedge nclk) begin
        if (rst) begin
            out_val_q   <= '0;
            out_instr_q <= '0;
            rr_ptr_q    <= '0;
        end else if (load_en) begin
            if (gnt_found) begin
                out_val_q   <= THREADS'(1) << gnt_idx;
                out_instr_q <= mem[gnt_idx][rd_ptr_q[gnt_idx]];
                rr_ptr_q    <= (gnt_idx == TW'(THREADS - 1)) ? '0 : gnt_idx + TW'(1);
            end else begin
                out_val_q <= '0;
            end
        end else if (|(out_val_q & replay)) begin
            // Flushed while stalled: drop the bus; the thread re-arbitrates.
            out_val_q <= '0;
        end
    end

`ifdef IUQ_RAM_TIMEOUT_EN
    localparam int TO_W_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TO_W     = (TO_W_RAW > 10) ? TO_W_RAW : 10;

    logic [TO_W-1:0]    to_cnt_q [THREADS];
    logic [THREADS-1:0] to_pulse_q;

    // Done in the same cycle beats the timeout.
    always_comb begin
        timeout_hit = '0;
        for (int t = 0; t < THREADS; t++) begin
            timeout_hit[t] = (state_q[t] == ST_WAIT) && (to_cnt_q[t] == TO_W'(TIMEOUT_CYCLES))
                             && !pop[t];
        end
    end

    // Held at zero outside WAIT, so it starts from zero on every WAIT entry.
    always_ff @(posedge nclk) begin
        if (rst) begin
            for (int t = 0; t < THREADS; t++) to_cnt_q[t] <= '0;
            to_pulse_q <= '0;
        end else begin
            for (int t = 0; t < THREADS; t++) begin
                if (state_q[t] == ST_WAIT) to_cnt_q[t] <= to_cnt_q[t] + TO_W'(1);
                else                       to_cnt_q[t] <= '0;
            end
            to_pulse_q <= timeout_hit;
        end
    end

    assign iu_pc_ram_timeout = to_pulse_q;
`else
    assign timeout_hit       = '0;
    assign iu_pc_ram_timeout = '0;
`endif

    assign rm_ib_iu3_val      = out_val_q;
    assign rm_ib_iu3_instr    = out_instr_q;
    assign iu_pc_ram_full     = full_q;
    assign iu_pc_ram_overflow = ovf_q;

endmodule
